// File: rtl/decode_stage_pkg.sv
// Shared opcode, format-index and buffer-state definitions for the decode stage.
package decode_stage_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/decode_stage_imm.sv
// Immediate generator: sign-extended immediate selected by the one-hot format.
module decode_stage_imm
  import decode_stage_pkg::*;
(
  input  logic [31:7] inst,
  input  logic [5:0]  format,
  output logic [31:0] imm
);

  // R and illegal (all-zero format) both fall through to zero
  always_comb begin
    imm = '0;
    if (format[FMT_R]) begin
      imm = '0;
    end else if (format[FMT_I]) begin
      imm = {{20{inst[31]}}, inst[31:20]};
    end else if (format[FMT_S]) begin
      imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    end else if (format[FMT_B]) begin
      imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    end else if (format[FMT_U]) begin
      imm = {inst[31:12], 12'h000};
    end else if (format[FMT_J]) begin
      imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: opcode classification, immediate generation and a
// 2-entry skid buffer with valid/ready on both sides.
//
// state | meaning
// EMPTY | no beat held; o_valid=0, o_ready=1
// BUSY  | main register holds the presented beat; skid free
// FULL  | main presented, skid holds the next beat; o_ready=0
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter bit ENABLE_SKID = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_inst,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_inst,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [5:0]          o_format,
  output logic [31:0]         o_immediate,
  output logic [4:0]          o_rs1,
  output logic [4:0]          o_rs2,
  output logic [4:0]          o_rd,
  output logic                o_illegal
);

  buf_state_e state_q, state_d;

  logic [5:0]  dec_format;
  logic        dec_illegal;
  logic [31:0] dec_imm;

  logic [31:0]         skid_inst;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [5:0]          skid_format;
  logic [31:0]         skid_imm;
  logic                skid_illegal;

  logic in_fire, out_fire;
  logic load_main, load_skid, main_from_skid;

  always_comb begin
    dec_format = '0;
    case (i_inst[6:0])
      OP_REG:                                          dec_format[FMT_R] = 1'b1;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:   dec_format[FMT_I] = 1'b1;
      OP_STORE:                                        dec_format[FMT_S] = 1'b1;
      OP_BRANCH:                                       dec_format[FMT_B] = 1'b1;
      OP_LUI, OP_AUIPC:                                dec_format[FMT_U] = 1'b1;
      OP_JAL:                                          dec_format[FMT_J] = 1'b1;
      default:                                         dec_format = '0;
    endcase
    dec_illegal = (dec_format == 6'b0) || (i_inst[1:0] != 2'b11);
  end

  decode_stage_imm u_imm (
    .inst   (i_inst[31:7]),
    .format (dec_format),
    .imm    (dec_imm)
  );

  assign o_valid  = (state_q != EMPTY);
  assign o_ready  = ENABLE_SKID ? (state_q != FULL) : ((state_q == EMPTY) || i_ready);
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          state_d        = BUSY;
          main_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inst       <= '0;
      o_pc         <= '0;
      o_format     <= '0;
      o_immediate  <= '0;
      o_illegal    <= 1'b0;
      skid_inst    <= '0;
      skid_pc      <= '0;
      skid_format  <= '0;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
    end else begin
      if (load_main) begin
        o_inst      <= i_inst;
        o_pc        <= i_pc;
        o_format    <= dec_format;
        o_immediate <= dec_imm;
        o_illegal   <= dec_illegal;
      end else if (main_from_skid) begin
        o_inst      <= skid_inst;
        o_pc        <= skid_pc;
        o_format    <= skid_format;
        o_immediate <= skid_imm;
        o_illegal   <= skid_illegal;
      end
      if (load_skid) begin
        skid_inst    <= i_inst;
        skid_pc      <= i_pc;
        skid_format  <= dec_format;
        skid_imm     <= dec_imm;
        skid_illegal <= dec_illegal;
      end
    end
  end

  assign o_rs1 = o_inst[19:15];
  assign o_rs2 = o_inst[24:20];
  assign o_rd  = o_inst[11:7];

endmodule
